// File: rtl/rob_commit.sv
// rob_commit: in-order retirement buffer for an out-of-order core.
//
// Entries are allocated at the tail in program order. Results arrive on the
// common data bus (CDB) in any order. Entries retire from the head in order,
// with at most one retirement per cycle.
//
// Ports:
//   clk, rst                   clock; synchronous active-low reset
//   alloc_valid/alloc_rd       allocation request and its destination register
//   alloc_ready/alloc_tag      a slot is free; tag given to the new entry (tail)
//   cdb_valid/cdb_tag/cdb_data result broadcast
//   flush                      discard every entry (mispredict recovery)
//   q_tag -> q_ready/q_data    operand lookup, with bypass from the CDB
//   commit_we/addr/data        register file write for the retiring entry
//   count                      number of occupied entries, 0..DEPTH
//
// Allocation handshake: an entry is taken on a rising edge where
// alloc_valid && alloc_ready && !flush. alloc_ready depends only on the
// registered count, never on alloc_valid, so the requester may hold
// alloc_valid high until it sees alloc_ready.
module rob_commit #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             flush,
  input  logic [TAG_W-1:0] q_tag,
  output logic             q_ready,
  output logic [31:0]      q_data,
  output logic             commit_we,
  output logic [4:0]       commit_addr,
  output logic [31:0]      commit_data,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic alloc_fire;
  logic cdb_fire;
  logic commit_fire;

  assign alloc_ready = (count_q < DEPTH_CNT);
  assign alloc_tag   = tail_q;
  assign count       = count_q;

  // Commit only looks at registered head state, so a result arriving on the
  // CDB this cycle cannot retire before the next cycle.
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign cdb_fire    = cdb_valid && busy_q[cdb_tag] && !flush;
  assign commit_fire = rst && !flush && busy_q[head_q] && done_q[head_q];

  always_comb begin
    commit_we   = 1'b0;
    commit_addr = 5'd0;
    commit_data = 32'd0;
    if (commit_fire) begin
      // Entries targeting x0 retire without writing the register file.
      commit_we   = (rd_q[head_q] != 5'd0);
      commit_addr = rd_q[head_q];
      commit_data = data_q[head_q];
    end
  end

  // Operand lookup: a result on the CDB this cycle takes precedence over the
  // stored copy so consumers never miss a just-broadcast value.
  always_comb begin
    q_ready = 1'b0;
    q_data  = 32'd0;
    if (rst) begin
      if (cdb_valid && (cdb_tag == q_tag)) begin
        q_ready = 1'b1;
        q_data  = cdb_data;
      end else if (done_q[q_tag]) begin
        q_ready = 1'b1;
        q_data  = data_q[q_tag];
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_fire) begin
        done_d[cdb_tag] = 1'b1;
        data_d[cdb_tag] = cdb_data;
      end
      // Commit needs count >= 1 and alloc needs count < DEPTH, so when both
      // fire head and tail are different slots.
      if (commit_fire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + TAG_W'(1);
      end
      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        rd_d[tail_q]   = alloc_rd;
        tail_d         = tail_q + TAG_W'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter DEPTH, 8, number of reorder entries (power of two).
REQ-002 SHALL have parameter TAG_W, 3, entry tag width (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port alloc_valid  input  1  issue requests a new entry.
REQ-006 SHALL have port alloc_rd  input  5  destination register of the new entry.
REQ-007 SHALL have port alloc_ready  output  1  entry available (count < DEPTH).
REQ-008 SHALL have port alloc_tag  output  TAG_W  tag given to the new entry (current tail index).
REQ-009 SHALL have port cdb_valid  input  1  result broadcast valid.
REQ-010 SHALL have port cdb_tag  input  TAG_W  entry the result belongs to.
REQ-011 SHALL have port cdb_data  input  32  result value.
REQ-012 SHALL have port flush  input  1  discard all entries (mispredict).
REQ-013 SHALL have port q_tag  input  TAG_W  operand lookup tag.
REQ-014 SHALL have port q_ready  output  1  looked-up entry holds its result.
REQ-015 SHALL have port q_data  output  32  looked-up entry result.
REQ-016 SHALL have port commit_we  output  1  register file write request.
REQ-017 SHALL have port commit_addr  output  5  register file write address.
REQ-018 SHALL have port commit_data  output  32  register file write data.
REQ-019 SHALL have port count  output  TAG_W+1  occupied entries, 0..DEPTH.

Function
REQ-020 SHALL store per entry: busy, done, rd[4:0], data[31:0]; head, tail pointers TAG_W bits, wrapping DEPTH-1 -> 0.
REQ-021 SHALL accept an allocation when alloc_valid && alloc_ready && !flush: entry[tail] <- busy=1, done=0, rd=alloc_rd; tail+1.
REQ-022 SHALL drive alloc_ready from registered count only; a same-cycle commit does not free a slot for allocation that cycle.
REQ-023 SHALL, on cdb_valid && entry[cdb_tag].busy && !flush, set done=1, data=cdb_data at next edge; CDB to a non-busy entry ignored.
REQ-024 SHALL commit combinationally from registered head state: commit fires when entry[head].busy && entry[head].done && !flush; at most one commit per cycle.
REQ-025 SHALL on commit drive commit_addr=rd, commit_data=data, commit_we=1 only if rd != 0; rd=0 entries retire silently with commit_we=0.
REQ-026 SHALL on commit clear entry[head].busy and advance head at next edge.
REQ-027 SHALL hold commit_we=0, commit_addr=0, commit_data=0 when no commit fires.
REQ-028 SHALL update count +1 alloc only, -1 commit only, unchanged for both or neither.
REQ-029 SHALL not commit a CDB result in the cycle it arrives; earliest commit is the following cycle.
REQ-030 SHALL drive q_ready/q_data combinationally: cdb_valid && cdb_tag==q_tag -> 1/cdb_data; else entry done -> 1/data; else 0/0.
REQ-031 SHALL give flush priority over alloc, CDB and commit: next edge all busy=0, done=0, head=tail=0, count=0.
REQ-032 SHALL keep alloc_tag = tail in every cycle, including when full.

Reset
REQ-033 SHALL, while rst=0 at a clock edge, clear all entries, head=tail=0, count=0; alloc_ready=1 after the edge.
REQ-034 SHALL force commit_we=0, q_ready=0 in any cycle rst=0 is asserted, regardless of state (reset mid-operation discards entries).

Verification
REQ-035 SHALL cover alloc rd=5 (tag 0), next cycle CDB tag0 data 0x1234 -> following cycle commit_we=1, addr=5, data=0x1234; count 1->0.
REQ-036 SHALL cover 8 allocs without commit -> count=8, alloc_ready=0; 9th alloc_valid ignored, tail stays 0.
REQ-037 SHALL cover out-of-order completion: alloc tags 0,1,2; CDB order 2,1,0 -> commits in order 0,1,2 on consecutive cycles.
REQ-038 SHALL cover full ROB with head done: commit and alloc_valid same cycle -> alloc refused, count 8->7; next cycle alloc accepted at tag 0 (wrap).
REQ-039 SHALL cover flush with 3 busy entries and a coincident CDB and alloc -> next cycle count=0, commit_we=0, alloc_tag=0.
REQ-040 SHALL cover alloc rd=0, CDB data 0xFFFF -> entry retires, commit_we=0, count decrements; q_tag bypass during CDB cycle returns 0xFFFF.
